gemm_result_writeback: RTL and testbench

- Downstream consumer of the 4x4 GeMM controller/datapath.
- Accepts one completed 4x4 output tile (16 accumulators plus tile coordinates) per result_valid pulse and buffers up to two tiles.
- Serialises each tile to the output SRAM as four row-words, each word packing 4 accumulators, with generated row-major addresses.
- Reports idle/overflow status to the accelerator top.

---
 rtl/gemm_pkg.sv | 27 ++
 rtl/gemm_tile_fifo.sv | 52 +++++
 rtl/gemm_result_writeback.sv | 131 +++++++++++++
 tb/tb_gemm_result_writeback.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GeMM result write-back path.
// Provides the tile geometry, the write-back buffer depth, the write-back
// FSM state encoding and a tile-entry record at the default widths.
// No ports: this file is a package.
package gemm_pkg;

  localparam int TileDim   = 4;
  localparam int TileElems = TileDim * TileDim;
  localparam int BufDepth  = 2;

  // Default widths of the accelerator; modules carrying their own width
  // parameters declare a matching entry record locally.
  localparam int DefAddrWidth = 16;
  localparam int DefAccWidth  = 32;

  typedef enum logic {
    WbIdle,
    WbWrite
  } wb_state_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0]          m;
    logic [DefAddrWidth-1:0]          n;
    logic [TileElems*DefAccWidth-1:0] data;
  } tile_entry_t;

endpackage

// File: rtl/gemm_tile_fifo.sv
// Two-entry FIFO holding complete output tiles for the write-back FSM.
// Ports:
//   clk, rst  clock and asynchronous active-high reset (control state only)
//   push      write wdata into the tail entry (caller guarantees !full)
//   pop       retire the head entry (caller guarantees !empty)
//   wdata     entry being pushed
//   head      current head entry; a pushed entry is never visible on head
//             in the same cycle it is written
//   full      both entries occupied
//   empty     no entry occupied
module gemm_tile_fifo
  import gemm_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem [BufDepth];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage is plain data and needs no reset; occupancy is tracked above.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'(BufDepth));
  assign empty = (count == 2'd0);

endmodule

// File: rtl/gemm_result_writeback.sv
// Write-back stage behind the 4x4 GeMM datapath.
// Buffers up to two finished tiles and streams each one to the output SRAM
// as four row words (row-major addresses), with ready/valid on both sides.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   N_size_i        N matrix size in elements (multiple of 4, stable while busy)
//   tile_valid_i    tile offered; tile_ready_o = buffer has a free entry
//   tile_m_i/n_i    tile coordinates in 4-element units
//   tile_data_i     16 accumulators, element [r][c] at (r*4+c)*AccWidth
//   sram_we_o       write request, held until sram_ready_i
//   sram_addr_o     word address ((m*4+row)*(N/4)+n) mod 2^AddrWidth
//   sram_wdata_o    one tile row, column c at c*AccWidth
//   idle_o          nothing buffered and no write pending
//   overflow_o      sticky: a tile was offered while the buffer was full
module gemm_result_writeback
  import gemm_pkg::*;
#(
  parameter int AddrWidth = 16,
  parameter int AccWidth  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AddrWidth-1:0]          N_size_i,
  input  logic                          tile_valid_i,
  output logic                          tile_ready_o,
  input  logic [AddrWidth-1:0]          tile_m_i,
  input  logic [AddrWidth-1:0]          tile_n_i,
  input  logic [TileElems*AccWidth-1:0] tile_data_i,
  output logic                          sram_we_o,
  input  logic                          sram_ready_i,
  output logic [AddrWidth-1:0]          sram_addr_o,
  output logic [TileDim*AccWidth-1:0]   sram_wdata_o,
  output logic                          idle_o,
  output logic                          overflow_o
);

  localparam int         RowW    = TileDim * AccWidth;
  localparam logic [1:0] LastRow = 2'(TileDim - 1);

  typedef struct packed {
    logic [AddrWidth-1:0]          m;
    logic [AddrWidth-1:0]          n;
    logic [TileElems*AccWidth-1:0] data;
  } entry_t;

  entry_t         push_entry;
  entry_t         head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  wb_state_t      state_q;
  wb_state_t      state_d;
  logic [1:0]     row_q;
  logic [1:0]     row_d;
  logic           overflow_q;
  logic [AddrWidth-1:0] row_line;
  logic [AddrWidth-1:0] addr;

  // Ready depends only on buffer occupancy, never on sram_ready_i.
  assign tile_ready_o = !full;
  assign push         = tile_valid_i && !full;
  assign push_entry   = '{m: tile_m_i, n: tile_n_i, data: tile_data_i};

  gemm_tile_fifo #(
    .Width($bits(entry_t))
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= WbIdle;
      row_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (tile_valid_i && full) overflow_q <= 1'b1;
    end
  end

  // Idle also reacts to a push in flight so the first row goes out in the
  // cycle right after the accept edge. After the last row the FSM stays in
  // WbWrite when an entry remains: either a second buffered tile or one
  // being pushed on this same edge.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pop     = 1'b0;
    case (state_q)
      WbIdle: begin
        if (!empty || push) begin
          state_d = WbWrite;
          row_d   = 2'd0;
        end
      end
      WbWrite: begin
        if (sram_ready_i) begin
          if (row_q == LastRow) begin
            pop   = 1'b1;
            row_d = 2'd0;
            if (!full && !push) state_d = WbIdle;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      default: state_d = WbIdle;
    endcase
  end

  // The address is defined modulo 2^AddrWidth; the low AddrWidth bits of a
  // double-width product equal those of the single-width product.
  assign row_line = {head.m[AddrWidth-3:0], 2'b00} + AddrWidth'(row_q);
  assign addr     = row_line * (N_size_i >> 2) + head.n;

  assign sram_we_o    = (state_q == WbWrite);
  assign sram_addr_o  = sram_we_o ? addr : '0;
  assign sram_wdata_o = sram_we_o ? head.data[row_q*RowW +: RowW] : '0;
  assign idle_o       = empty && (state_q == WbIdle);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_gemm_result_writeback.sv
// Directed bench for gemm_result_writeback: single tile, back-to-back tiles,
// SRAM backpressure with overflow, push on the final row, asynchronous reset
// mid-tile, and address wrap on an 8-bit-address instance.
module tb_gemm_result_writeback;

  logic         clk;
  logic         rst;
  logic [15:0]  n_size;
  logic         tile_valid;
  logic         tile_ready;
  logic [15:0]  tile_m;
  logic [15:0]  tile_n;
  logic [511:0] tile_data;
  logic         sram_we;
  logic         sram_ready;
  logic [15:0]  sram_addr;
  logic [127:0] sram_wdata;
  logic         idle;
  logic         overflow;

  logic [7:0]   n_size8;
  logic         tile_valid8;
  logic         tile_ready8;
  logic [7:0]   tile_m8;
  logic [7:0]   tile_n8;
  logic [511:0] tile_data8;
  logic         sram_we8;
  logic         sram_ready8;
  logic [7:0]   sram_addr8;
  logic [127:0] sram_wdata8;
  logic         idle8;
  logic         overflow8;

  int checks = 0;
  int errors = 0;

  gemm_result_writeback #(.AddrWidth(16), .AccWidth(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .N_size_i     (n_size),
    .tile_valid_i (tile_valid),
    .tile_ready_o (tile_ready),
    .tile_m_i     (tile_m),
    .tile_n_i     (tile_n),
    .tile_data_i  (tile_data),
    .sram_we_o    (sram_we),
    .sram_ready_i (sram_ready),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .idle_o       (idle),
    .overflow_o   (overflow)
  );

  gemm_result_writeback #(.AddrWidth(8), .AccWidth(32)) dut8 (
    .clk_i        (clk),
    .rst_i        (rst),
    .N_size_i     (n_size8),
    .tile_valid_i (tile_valid8),
    .tile_ready_o (tile_ready8),
    .tile_m_i     (tile_m8),
    .tile_n_i     (tile_n8),
    .tile_data_i  (tile_data8),
    .sram_we_o    (sram_we8),
    .sram_ready_i (sram_ready8),
    .sram_addr_o  (sram_addr8),
    .sram_wdata_o (sram_wdata8),
    .idle_o       (idle8),
    .overflow_o   (overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element [r][c] of a tile is base + r*4 + c + 1.
  function automatic logic [511:0] make_tile(input int base);
    logic [511:0] d;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        d[(r*4+c)*32 +: 32] = 32'(base + r*4 + c + 1);
    return d;
  endfunction

  function automatic logic [127:0] row_word(input int base, input int r);
    logic [127:0] w;
    for (int c = 0; c < 4; c++)
      w[c*32 +: 32] = 32'(base + r*4 + c + 1);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tile(input int m, input int n, input int base);
    tile_valid = 1'b1;
    tile_m     = 16'(m);
    tile_n     = 16'(n);
    tile_data  = make_tile(base);
  endtask

  task automatic check_write(input string tag, input int exp_addr, input int base, input int r);
    @(negedge clk);
    check($sformatf("%s.we", tag), 128'(sram_we), 128'(1));
    check($sformatf("%s.addr", tag), 128'(sram_addr), 128'(exp_addr));
    check($sformatf("%s.wdata", tag), sram_wdata, row_word(base, r));
  endtask

  initial begin
    rst         = 1'b1;
    n_size      = 16'd8;
    tile_valid  = 1'b0;
    tile_m      = '0;
    tile_n      = '0;
    tile_data   = '0;
    sram_ready  = 1'b1;
    n_size8     = 8'd64;
    tile_valid8 = 1'b0;
    tile_m8     = '0;
    tile_n8     = '0;
    tile_data8  = '0;
    sram_ready8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.we", 128'(sram_we), 128'(0));
    check("rst.addr", 128'(sram_addr), 128'(0));
    check("rst.wdata", sram_wdata, 128'(0));
    check("rst.ready", 128'(tile_ready), 128'(1));
    check("rst.idle", 128'(idle), 128'(1));
    check("rst.overflow", 128'(overflow), 128'(0));
    step();
    rst = 1'b0;
    step();

    // Single tile (1,1), N=8: addresses 9,11,13,15
    drive_tile(1, 1, 0);
    step();
    tile_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      check_write($sformatf("single.r%0d", r), 9 + 2*r, 0, r);
      step();
    end
    @(negedge clk);
    check("single.done.we", 128'(sram_we), 128'(0));
    check("single.done.idle", 128'(idle), 128'(1));
    step();

    // Back-to-back tiles (0,0),(0,1): eight writes with no bubble
    drive_tile(0, 0, 100);
    step();
    drive_tile(0, 1, 200);
    check_write("b2b.t0.r0", 0, 100, 0);
    check("b2b.ready_t1", 128'(tile_ready), 128'(1));
    step();
    tile_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check_write($sformatf("b2b.w%0d", i), (i < 4) ? 2*i : 2*(i-4) + 1,
                  (i < 4) ? 100 : 200, i % 4);
      step();
    end
    @(negedge clk);
    check("b2b.done.idle", 128'(idle), 128'(1));
    step();

    // Three tiles offered back to back, then a 5-cycle stall on row 2
    drive_tile(2, 0, 300);
    step();
    drive_tile(2, 1, 400);
    check_write("bp.a.r0", 16, 300, 0);
    check("bp.ready_b", 128'(tile_ready), 128'(1));
    step();
    drive_tile(3, 0, 500);
    check_write("bp.a.r1", 18, 300, 1);
    check("bp.ready_c", 128'(tile_ready), 128'(0));
    step();
    tile_valid = 1'b0;
    sram_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check_write($sformatf("bp.stall%0d", s), 20, 300, 2);
      check($sformatf("bp.overflow%0d", s), 128'(overflow), 128'(1));
      step();
    end
    sram_ready = 1'b1;
    check_write("bp.a.r2", 20, 300, 2);
    step();
    check_write("bp.a.r3", 22, 300, 3);
    step();
    for (int r = 0; r < 4; r++) begin
      check_write($sformatf("bp.b.r%0d", r), 17 + 2*r, 400, r);
      step();
    end
    @(negedge clk);
    check("bp.done.idle", 128'(idle), 128'(1));
    check("bp.done.overflow", 128'(overflow), 128'(1));
    step();

    // Push on the final-row accept at count 1: next tile follows directly
    drive_tile(0, 0, 600);
    step();
    tile_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check_write($sformatf("fin.d.r%0d", r), 2*r, 600, r);
      step();
    end
    drive_tile(1, 0, 700);
    check_write("fin.d.r3", 6, 600, 3);
    check("fin.ready_e", 128'(tile_ready), 128'(1));
    step();
    tile_valid = 1'b0;
    check_write("fin.e.r0", 8, 700, 0);
    check("fin.ready_after", 128'(tile_ready), 128'(1));
    step();
    for (int r = 1; r < 4; r++) begin
      check_write($sformatf("fin.e.r%0d", r), 8 + 2*r, 700, r);
      step();
    end
    @(negedge clk);
    check("fin.done.idle", 128'(idle), 128'(1));
    step();

    // Asynchronous reset while row 1 is on the bus
    drive_tile(1, 0, 800);
    step();
    tile_valid = 1'b0;
    check_write("arst.f.r0", 8, 800, 0);
    step();
    check_write("arst.f.r1", 10, 800, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.we", 128'(sram_we), 128'(0));
    check("arst.idle", 128'(idle), 128'(1));
    check("arst.overflow", 128'(overflow), 128'(0));
    check("arst.addr", 128'(sram_addr), 128'(0));
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("arst.quiet%0d", i), 128'(sram_we), 128'(0));
      step();
    end
    drive_tile(0, 1, 900);
    step();
    tile_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      check_write($sformatf("arst.g.r%0d", r), 1 + 2*r, 900, r);
      step();
    end

    // 8-bit address wrap: N=64, m=20, n=3 -> (80+r)*16+3 mod 256 = 3,19,35,51
    tile_valid8 = 1'b1;
    tile_m8     = 8'd20;
    tile_n8     = 8'd3;
    tile_data8  = make_tile(1000);
    step();
    tile_valid8 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      check($sformatf("wrap.r%0d.we", r), 128'(sram_we8), 128'(1));
      check($sformatf("wrap.r%0d.addr", r), 128'(sram_addr8), 128'(3 + 16*r));
      check($sformatf("wrap.r%0d.wdata", r), sram_wdata8, row_word(1000, r));
      step();
    end
    @(negedge clk);
    check("wrap.done.idle", 128'(idle8), 128'(1));
    check("wrap.overflow", 128'(overflow8), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
